bullet_scheduler: RTL and testbench

- Frame-rate scheduler that shares a fixed pool of bullet slots between the two tanks.
- Decodes each tank's fire key from the USB keycode word and enforces per-tank cooldown and per-tank bullet limits.
- Arbitrates simultaneous fire requests round-robin, loads the chosen slot with the tank's position and angle, and ages or retires slots.
- Sits between the keyboard/tank blocks and the bullet motion and collision logic.

---
 rtl/bullet_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_bullet_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_scheduler.sv
// bullet_scheduler: shares a pool of bullet slots between two tanks.
// Each frame it decodes both fire keys from the USB keycode word and applies
// the per-tank cooldown and bullet limits. It grants at most one slot per
// frame, using round-robin on contested frames, and ages or retires live slots.
// Optional build macro BULLET_SCHED_STATS_EN adds saturating per-tank shot
// counters (shots1, shots2).
module bullet_scheduler #(
   parameter int unsigned NUM_SLOTS    = 4,
   parameter int unsigned MAX_PER_TANK = 2,
   parameter int unsigned LIFETIME     = 600,
   parameter int unsigned COOLDOWN     = 15,
   parameter logic [7:0]  FIRE1_KEY    = 8'h2C,
   parameter logic [7:0]  FIRE2_KEY    = 8'h28
) (
   input  logic                 frame_clk,
   input  logic                 Reset,
   input  logic [31:0]          keycode,
   input  logic                 round_clear,
   input  logic [9:0]           tank1_x,
   input  logic [9:0]           tank1_y,
   input  logic [4:0]           tank1_angle,
   input  logic [9:0]           tank2_x,
   input  logic [9:0]           tank2_y,
   input  logic [4:0]           tank2_angle,
   input  logic [NUM_SLOTS-1:0] slot_kill,
   output logic [NUM_SLOTS-1:0] slot_active,
   output logic [NUM_SLOTS-1:0] slot_owner,
   output logic [NUM_SLOTS-1:0] spawn_stb,
   output logic [9:0]           spawn_x,
   output logic [9:0]           spawn_y,
   output logic [4:0]           spawn_angle
`ifdef BULLET_SCHED_STATS_EN
   ,
   output logic [15:0]          shots1,
   output logic [15:0]          shots2
`endif
);

   localparam int unsigned LIFE_W = $clog2(LIFETIME + 1);
   localparam int unsigned CD_W   = $clog2(COOLDOWN + 1);
   localparam int unsigned CNT_W  = $clog2(NUM_SLOTS + 1);
   localparam int unsigned IDX_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   typedef enum logic {TANK1 = 1'b0, TANK2 = 1'b1} tank_e;

   logic [LIFE_W-1:0] life [NUM_SLOTS];
   logic [CD_W-1:0]   cd1, cd2;
   logic              pend1, pend2;
   logic              fire1_prev, fire2_prev;
   tank_e             ptr;

   logic              fire1_lvl, fire2_lvl;
   logic              accept1, accept2;
   logic [CNT_W-1:0]  owned1, owned2;
   logic              free_vld;
   logic [IDX_W-1:0]  free_idx;
   logic              grant, grant1, grant2;
   tank_e             grant_tank;

   // Key decode, ownership counts, free-slot search and the grant decision
   always_comb begin
      fire1_lvl = 1'b0;
      fire2_lvl = 1'b0;
      for (int unsigned b = 0; b < 4; b++) begin
         if (keycode[8*b +: 8] == FIRE1_KEY) fire1_lvl = 1'b1;
         if (keycode[8*b +: 8] == FIRE2_KEY) fire2_lvl = 1'b1;
      end

      owned1 = '0;
      owned2 = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (slot_active[i]) begin
            if (slot_owner[i]) owned2 = owned2 + CNT_W'(1);
            else               owned1 = owned1 + CNT_W'(1);
         end
      end

      // Scan from the top so that the lowest free index wins
      free_vld = 1'b0;
      free_idx = '0;
      for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
         if (!slot_active[i-1]) begin
            free_vld = 1'b1;
            free_idx = IDX_W'(i - 1);
         end
      end

      accept1 = fire1_lvl && !fire1_prev && (cd1 == '0) &&
                (owned1 < CNT_W'(MAX_PER_TANK)) && !pend1;
      accept2 = fire2_lvl && !fire2_prev && (cd2 == '0) &&
                (owned2 < CNT_W'(MAX_PER_TANK)) && !pend2;

      grant      = free_vld && (pend1 || pend2);
      grant_tank = TANK1;
      if (pend1 && pend2) grant_tank = ptr;
      else if (pend2)     grant_tank = TANK2;
      grant1 = grant && (grant_tank == TANK1);
      grant2 = grant && (grant_tank == TANK2);
   end

   // Slot pool, per-tank pend/cooldown, round-robin pointer and spawn outputs
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         slot_active <= '0;
         slot_owner  <= '0;
         spawn_stb   <= '0;
         spawn_x     <= '0;
         spawn_y     <= '0;
         spawn_angle <= '0;
         for (int unsigned i = 0; i < NUM_SLOTS; i++) life[i] <= '0;
         cd1         <= '0;
         cd2         <= '0;
         pend1       <= 1'b0;
         pend2       <= 1'b0;
         fire1_prev  <= 1'b0;
         fire2_prev  <= 1'b0;
         ptr         <= TANK1;
      end else begin
         fire1_prev <= fire1_lvl;
         fire2_prev <= fire2_lvl;
         if (round_clear) begin
            slot_active <= '0;
            slot_owner  <= '0;
            spawn_stb   <= '0;
            spawn_x     <= '0;
            spawn_y     <= '0;
            spawn_angle <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) life[i] <= '0;
            cd1         <= '0;
            cd2         <= '0;
            pend1       <= 1'b0;
            pend2       <= 1'b0;
            ptr         <= TANK1;
         end else begin
            if (grant1)                 cd1 <= CD_W'(COOLDOWN);
            else if (cd1 != '0)         cd1 <= cd1 - CD_W'(1);
            if (grant2)                 cd2 <= CD_W'(COOLDOWN);
            else if (cd2 != '0)         cd2 <= cd2 - CD_W'(1);

            if (grant1)                 pend1 <= 1'b0;
            else if (accept1)           pend1 <= 1'b1;
            if (grant2)                 pend2 <= 1'b0;
            else if (accept2)           pend2 <= 1'b1;

            if (grant && pend1 && pend2) ptr <= (ptr == TANK1) ? TANK2 : TANK1;

            // A grant only targets an inactive slot, so it never meets kill/expiry
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
               if (grant && (free_idx == IDX_W'(i))) begin
                  slot_active[i] <= 1'b1;
                  slot_owner[i]  <= grant_tank;
                  life[i]        <= LIFE_W'(LIFETIME);
               end else if (slot_active[i]) begin
                  if (slot_kill[i] || (life[i] == LIFE_W'(1))) begin
                     slot_active[i] <= 1'b0;
                     life[i]        <= '0;
                  end else begin
                     life[i] <= life[i] - LIFE_W'(1);
                  end
               end
            end

            spawn_stb <= '0;
            if (grant) begin
               spawn_stb[free_idx] <= 1'b1;
               spawn_x     <= grant1 ? tank1_x     : tank2_x;
               spawn_y     <= grant1 ? tank1_y     : tank2_y;
               spawn_angle <= grant1 ? tank1_angle : tank2_angle;
            end
         end
      end
   end

`ifdef BULLET_SCHED_STATS_EN
   // Saturating shot counters; they survive round_clear and reset only on Reset
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         shots1 <= '0;
         shots2 <= '0;
      end else if (!round_clear) begin
         if (grant1 && (shots1 != '1)) shots1 <= shots1 + 16'd1;
         if (grant2 && (shots2 != '1)) shots2 <= shots2 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bullet_scheduler.sv
// Self-checking bench for bullet_scheduler: a table of frame vectors,
// hand sequences for expiry/clear/async reset, and a randomized run against
// a frame-level reference model of the slot pool.
module tb_bullet_scheduler;

   localparam int NS   = 4;
   localparam int MAXT = 2;
   localparam int LIFE = 600;
   localparam int CD   = 15;

   logic          frame_clk = 1'b0;
   logic          Reset;
   logic [31:0]   keycode;
   logic          round_clear;
   logic [9:0]    tank1_x, tank1_y, tank2_x, tank2_y;
   logic [4:0]    tank1_angle, tank2_angle;
   logic [NS-1:0] slot_kill;
   logic [NS-1:0] slot_active, slot_owner, spawn_stb;
   logic [9:0]    spawn_x, spawn_y;
   logic [4:0]    spawn_angle;

   bullet_scheduler dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .keycode     (keycode),
      .round_clear (round_clear),
      .tank1_x     (tank1_x),
      .tank1_y     (tank1_y),
      .tank1_angle (tank1_angle),
      .tank2_x     (tank2_x),
      .tank2_y     (tank2_y),
      .tank2_angle (tank2_angle),
      .slot_kill   (slot_kill),
      .slot_active (slot_active),
      .slot_owner  (slot_owner),
      .spawn_stb   (spawn_stb),
      .spawn_x     (spawn_x),
      .spawn_y     (spawn_y),
      .spawn_angle (spawn_angle)
   );

   always #5 frame_clk = ~frame_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (frame-level) ----------------
   int         m_life [NS];   // frames left; 0 means slot free
   bit         m_own  [NS];
   int         m_cd   [2];
   bit         m_pend [2];
   bit         m_prev [2];
   int         m_ptr;
   logic [3:0] m_stb;
   logic [9:0] m_sx, m_sy;
   logic [4:0] m_sa;

   function automatic bit key_down(input logic [31:0] kc, input logic [7:0] k);
      for (int b = 0; b < 4; b++) if (kc[8*b +: 8] == k) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin m_life[i] = 0; m_own[i] = 0; end
      for (int t = 0; t < 2; t++) begin m_cd[t] = 0; m_pend[t] = 0; m_prev[t] = 0; end
      m_ptr = 0; m_stb = '0; m_sx = '0; m_sy = '0; m_sa = '0;
   endtask

   task automatic model_step();
      bit lvl [2];
      int owned [2];
      int free, gt;
      bit accept;
      lvl[0] = key_down(keycode, 8'h2C);
      lvl[1] = key_down(keycode, 8'h28);
      if (round_clear) begin
         model_reset();
         m_prev[0] = lvl[0]; m_prev[1] = lvl[1];
         return;
      end
      owned[0] = 0; owned[1] = 0;
      for (int i = 0; i < NS; i++) if (m_life[i] > 0) owned[m_own[i]]++;
      free = -1;
      for (int i = NS - 1; i >= 0; i--) if (m_life[i] == 0) free = i;
      gt = -1;
      if (free >= 0) begin
         if (m_pend[0] && m_pend[1]) begin gt = m_ptr; m_ptr = 1 - m_ptr; end
         else if (m_pend[0]) gt = 0;
         else if (m_pend[1]) gt = 1;
      end
      for (int i = 0; i < NS; i++) begin
         if (gt >= 0 && i == free) begin m_life[i] = LIFE; m_own[i] = gt[0]; end
         else if (m_life[i] > 0)   m_life[i] = slot_kill[i] ? 0 : m_life[i] - 1;
      end
      m_stb = '0;
      if (gt >= 0) begin
         m_stb[free] = 1'b1;
         m_sx = (gt == 0) ? tank1_x : tank2_x;
         m_sy = (gt == 0) ? tank1_y : tank2_y;
         m_sa = (gt == 0) ? tank1_angle : tank2_angle;
      end
      for (int t = 0; t < 2; t++) begin
         accept = lvl[t] && !m_prev[t] && m_cd[t] == 0 && owned[t] < MAXT && !m_pend[t];
         if (gt == t)     m_pend[t] = 0;
         else if (accept) m_pend[t] = 1;
         m_cd[t] = (gt == t) ? CD : ((m_cd[t] > 0) ? m_cd[t] - 1 : 0);
         m_prev[t] = lvl[t];
      end
   endtask

   task automatic cmp_model(input int frame);
      logic [3:0] ea, eo;
      for (int i = 0; i < NS; i++) begin
         ea[i] = (m_life[i] > 0);
         eo[i] = ea[i] & m_own[i];
      end
      chk($sformatf("rand%0d active", frame), slot_active, ea);
      chk($sformatf("rand%0d owner", frame), slot_owner & slot_active, eo);
      chk($sformatf("rand%0d stb", frame), spawn_stb, m_stb);
      chk($sformatf("rand%0d spawn_x", frame), spawn_x, m_sx);
      chk($sformatf("rand%0d spawn_y", frame), spawn_y, m_sy);
      chk($sformatf("rand%0d spawn_angle", frame), spawn_angle, m_sa);
   endtask

   // One frame: inputs already driven; outputs sampled 1 time unit after the edge
   task automatic tick();
      @(posedge frame_clk);
      #1;
      model_step();
   endtask

   task automatic reset_dut();
      Reset = 1'b1; keycode = '0; round_clear = 1'b0; slot_kill = '0;
      @(negedge frame_clk);
      model_reset();
      chk("reset active", slot_active, 4'b0000);
      chk("reset owner", slot_owner, 4'b0000);
      chk("reset stb", spawn_stb, 4'b0000);
      chk("reset spawn", {spawn_x, spawn_y, spawn_angle}, 25'd0);
      Reset = 1'b0;
   endtask

   typedef struct {
      logic [31:0] kc;
      logic [3:0]  kill;
      int          n;
      logic [3:0]  act;
      logic [3:0]  own;
      logic [3:0]  stb;
      logic [9:0]  sx;
   } vec_t;

   vec_t tbl [16];
   int   live, spurious;
   logic [31:0] kc;
   logic [7:0]  by;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      tank1_x = 10'd300; tank1_y = 10'd250; tank1_angle = 5'd7;
      tank2_x = 10'd100; tank2_y = 10'd400; tank2_angle = 5'd20;
      reset_dut();

      // kc, kill, frames, active, owner(masked), stb, spawn_x
      tbl[0]  = '{32'h00002C28, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 10'd0};
      tbl[1]  = '{32'h00002C28, 4'b0000,  1, 4'b0001, 4'b0000, 4'b0001, 10'd300};
      tbl[2]  = '{32'h00000000, 4'b0000,  1, 4'b0011, 4'b0010, 4'b0010, 10'd100};
      tbl[3]  = '{32'h00000000, 4'b0000,  1, 4'b0011, 4'b0010, 4'b0000, 10'd100};
      tbl[4]  = '{32'h00000000, 4'b0000, 14, 4'b0011, 4'b0010, 4'b0000, 10'd100};
      tbl[5]  = '{32'h0000002C, 4'b0000,  1, 4'b0011, 4'b0010, 4'b0000, 10'd100};
      tbl[6]  = '{32'h0000002C, 4'b0000,  1, 4'b0111, 4'b0010, 4'b0100, 10'd300};
      tbl[7]  = '{32'h28000000, 4'b0000,  1, 4'b0111, 4'b0010, 4'b0000, 10'd300};
      tbl[8]  = '{32'h00000000, 4'b0000,  1, 4'b1111, 4'b1010, 4'b1000, 10'd100};
      tbl[9]  = '{32'h00000000, 4'b0000, 16, 4'b1111, 4'b1010, 4'b0000, 10'd100};
      tbl[10] = '{32'h002C0000, 4'b0000,  1, 4'b1111, 4'b1010, 4'b0000, 10'd100};
      tbl[11] = '{32'h00000000, 4'b0100,  1, 4'b1011, 4'b1010, 4'b0000, 10'd100};
      tbl[12] = '{32'h0000002C, 4'b0000,  1, 4'b1011, 4'b1010, 4'b0000, 10'd100};
      tbl[13] = '{32'h00000000, 4'b0000,  1, 4'b1111, 4'b1010, 4'b0100, 10'd300};
      tbl[14] = '{32'h00000000, 4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 10'd300};
      tbl[15] = '{32'h00000000, 4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 10'd300};
      for (int i = 0; i < 16; i++) begin
         keycode = tbl[i].kc; slot_kill = tbl[i].kill;
         repeat (tbl[i].n) tick();
         chk($sformatf("vec%0d active", i), slot_active, tbl[i].act);
         chk($sformatf("vec%0d owner", i), slot_owner & slot_active, tbl[i].own);
         chk($sformatf("vec%0d stb", i), spawn_stb, tbl[i].stb);
         chk($sformatf("vec%0d spawn_x", i), spawn_x, tbl[i].sx);
      end
      slot_kill = '0;

      // Single shot, full lifetime, and a re-press during cooldown
      reset_dut();
      keycode = 32'h0000002C; tick();
      chk("shot pend-only active", slot_active, 4'b0000);
      chk("shot pend-only stb", spawn_stb, 4'b0000);
      keycode = '0; tick();
      chk("shot stb", spawn_stb, 4'b0001);
      chk("shot spawn", {spawn_x, spawn_y, spawn_angle}, {10'd300, 10'd250, 5'd7});
      chk("shot active", slot_active, 4'b0001);
      chk("shot owner0", slot_owner[0], 1'b0);
      live = 1; spurious = 0;
      for (int f = 0; f < 700 && slot_active[0]; f++) begin
         keycode = (live == 5) ? 32'h0000002C : 32'h0;
         tick();
         if (slot_active[0]) live++;
         if (spawn_stb !== 4'b0000) spurious++;
      end
      chk("expiry lifetime", live, LIFE);
      chk("expiry no respawn", spurious, 0);
      chk("expiry active", slot_active, 4'b0000);

      // round_clear with three live bullets and tank 2 pending
      reset_dut();
      keycode = 32'h00002C28; tick(); tick();
      keycode = '0; tick();
      repeat (16) tick();
      keycode = 32'h0000002C; tick();
      keycode = '0; tick();
      chk("clr setup active", slot_active, 4'b0111);
      keycode = 32'h00000028; tick();
      keycode = '0; round_clear = 1'b1; tick();
      round_clear = 1'b0;
      chk("clr active", slot_active, 4'b0000);
      chk("clr owner", slot_owner, 4'b0000);
      chk("clr stb", spawn_stb, 4'b0000);
      chk("clr spawn", {spawn_x, spawn_y, spawn_angle}, 25'd0);
      tick();
      chk("clr pend dropped", spawn_stb, 4'b0000);
      keycode = 32'h2C280000; tick(); tick();
      chk("clr ptr stb", spawn_stb, 4'b0001);
      chk("clr ptr owner", slot_owner[0], 1'b0);
      keycode = '0; tick();
      chk("rr second stb", spawn_stb, 4'b0010);
      chk("rr second owner", slot_owner & slot_active, 4'b0010);

      // Asynchronous Reset mid-frame
      #3 Reset = 1'b1;
      #1;
      chk("async active", slot_active, 4'b0000);
      chk("async owner", slot_owner, 4'b0000);
      chk("async spawn", {spawn_x, spawn_y, spawn_angle}, 25'd0);
      #2 Reset = 1'b0;
      model_reset();
      tick();
      chk("post-reset stb", spawn_stb, 4'b0000);
      chk("post-reset active", slot_active, 4'b0000);

      // Randomized frames against the reference model
      reset_dut();
      for (int f = 0; f < 3000; f++) begin
         if ($urandom_range(0, 2) == 0) begin
            for (int b = 0; b < 4; b++) begin
               case ($urandom_range(0, 7))
                  0:       by = 8'h2C;
                  1:       by = 8'h28;
                  2:       by = 8'($urandom);
                  default: by = 8'h00;
               endcase
               kc[8*b +: 8] = by;
            end
            keycode = kc;
         end
         for (int i = 0; i < NS; i++) slot_kill[i] = ($urandom_range(0, 15) == 0);
         round_clear = ($urandom_range(0, 199) == 0);
         tank1_x = 10'($urandom); tank1_y = 10'($urandom); tank1_angle = 5'($urandom);
         tank2_x = 10'($urandom); tank2_y = 10'($urandom); tank2_angle = 5'($urandom);
         tick();
         cmp_model(f);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
